instr_encoder: RTL and testbench

Field-to-word RV32I instruction encoder. It performs the inverse of the control decoder: it packs opcode, register and immediate fields into 32-bit instruction words. It sits between the self-test/boot sequencer and instruction memory, and it is also used by the verification bench to generate stimulus. Encoded words are queued in an output FIFO with valid/ready handshakes on both sides. Illegal field combinations are flagged and counted.

---
 rtl/instr_encoder.sv | 191 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs opcode/register/immediate fields into a
// 32-bit instruction, flags illegal field sets, and queues results in a FIFO.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_6,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [31:0]      NOP_WORD  = 32'h0000_0013;
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_STEP  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(1);
  localparam logic [CNT_W-1:0] STAT_ONE  = CNT_W'(1);

  // True when v is representable as a signed value of the given bit width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (&hi);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  function automatic logic [31:0] fmt_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm12, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] fmt_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] fmt_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] opc);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
  endfunction

  function automatic logic [31:0] fmt_j(input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
  endfunction

  // ---- Stage p0: combinational encode of the presented field set ----
  logic [6:0]  opc_p0;
  logic [31:0] raw_p0;
  logic        bad_p0;
  logic [31:0] word_p0;
  logic        shift_p0;

  assign opc_p0   = {in_op, 2'b11};
  assign shift_p0 = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  always_comb begin
    raw_p0 = '0;
    bad_p0 = 1'b0;
    case (in_op)
      OP_REG: begin
        raw_p0 = {1'b0, in_funct7_6, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, opc_p0};
        bad_p0 = in_funct7_6 && !((in_funct3 == 3'b000) || (in_funct3 == 3'b101));
      end
      OP_IMM: begin
        if (shift_p0) begin
          raw_p0 = fmt_i({1'b0, in_funct7_6, 5'b0, in_imm[4:0]}, in_rs1, in_funct3,
                         in_rd, opc_p0);
          bad_p0 = (|in_imm[31:5]) || (in_funct7_6 && (in_funct3 != 3'b101));
        end else begin
          raw_p0 = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, opc_p0);
          bad_p0 = !fits_signed(in_imm, 12) || in_funct7_6;
        end
      end
      OP_LOAD: begin
        raw_p0 = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, opc_p0);
        bad_p0 = !fits_signed(in_imm, 12) || (in_funct3 == 3'b011) ||
                 (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
      end
      OP_JALR: begin
        raw_p0 = fmt_i(in_imm[11:0], in_rs1, in_funct3, in_rd, opc_p0);
        bad_p0 = !fits_signed(in_imm, 12) || (in_funct3 != 3'b000);
      end
      OP_STORE: begin
        raw_p0 = fmt_s(in_imm, in_rs2, in_rs1, in_funct3, opc_p0);
        bad_p0 = !fits_signed(in_imm, 12) || (in_funct3 > 3'b010);
      end
      OP_BRANCH: begin
        raw_p0 = fmt_b(in_imm, in_rs2, in_rs1, in_funct3, opc_p0);
        bad_p0 = !fits_signed(in_imm, 13) || in_imm[0] ||
                 (in_funct3 == 3'b010) || (in_funct3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        raw_p0 = {in_imm[31:12], in_rd, opc_p0};
        bad_p0 = |in_imm[11:0];
      end
      OP_JAL: begin
        raw_p0 = fmt_j(in_imm, in_rd, opc_p0);
        bad_p0 = !fits_signed(in_imm, 21) || in_imm[0];
      end
      default: begin
        raw_p0 = '0;
        bad_p0 = 1'b1;
      end
    endcase
  end

  assign word_p0 = bad_p0 ? NOP_WORD : raw_p0;

  // ---- Stage p1: output FIFO and statistics ----
  logic [31:0]      mem_instr [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign in_ready  = (count < FIFO_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = mem_instr[rd_ptr];
  assign out_err   = mem_err[rd_ptr];

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      enc_count <= '0;
      err_count <= '0;
      mem_err   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= word_p0;
        mem_err[wr_ptr]   <= bad_p0;
        wr_ptr            <= wr_ptr + PTR_STEP;
        if (bad_p0) begin
          err_count <= sat_inc(err_count);
        end else begin
          enc_count <= sat_inc(enc_count);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_STEP;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_STEP;
        2'b01:   count <= count - CNT_STEP;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus randomized traffic scored
// against a queue-based reference model of the encoder and its FIFO.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [2:0]       in_funct3;
  logic             in_funct7_6;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct3(in_funct3), .in_funct7_6(in_funct7_6),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  typedef struct { logic [31:0] w; logic e; } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   enc_m = 0;
  int   err_m = 0;
  int   accepted = 0;
  bit   last_acc = 0;

  logic [4:0] legal_ops [10] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                 5'b00101, 5'b01101, 5'b11011, 5'b11001, 5'b00100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: instruction formats written out as shifted fields, with legality
  // decided by signed integer ranges.
  function automatic void ref_encode(input logic [4:0] op, input logic [2:0] f3,
                                     input logic f76, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm,
                                     output logic [31:0] w, output logic e);
    int          si;
    bit          r12;
    logic [31:0] opc, x_rd, x_rs1, x_rs2, x_f3, x_f76;
    si    = imm;
    r12   = (si < -2048) || (si > 2047);
    opc   = 32'(op) * 4 + 3;
    x_rd  = 32'(rd) << 7;
    x_rs1 = 32'(rs1) << 15;
    x_rs2 = 32'(rs2) << 20;
    x_f3  = 32'(f3) << 12;
    x_f76 = 32'(f76) << 30;
    w = 0;
    e = 0;
    case (op)
      5'b01100: begin
        w = x_f76 | x_rs2 | x_rs1 | x_f3 | x_rd | opc;
        e = f76 && !(f3 == 0 || f3 == 5);
      end
      5'b00100: begin
        if (f3 == 1 || f3 == 5) begin
          w = x_f76 | ((imm & 31) << 20) | x_rs1 | x_f3 | x_rd | opc;
          e = (imm > 31) || (f76 && f3 != 5);
        end else begin
          w = ((imm & 32'hFFF) << 20) | x_rs1 | x_f3 | x_rd | opc;
          e = r12 || f76;
        end
      end
      5'b00000: begin
        w = ((imm & 32'hFFF) << 20) | x_rs1 | x_f3 | x_rd | opc;
        e = r12 || f3 == 3 || f3 == 6 || f3 == 7;
      end
      5'b11001: begin
        w = ((imm & 32'hFFF) << 20) | x_rs1 | x_f3 | x_rd | opc;
        e = r12 || f3 != 0;
      end
      5'b01000: begin
        w = (((imm >> 5) & 127) << 25) | x_rs2 | x_rs1 | x_f3 | ((imm & 31) << 7) | opc;
        e = r12 || f3 > 2;
      end
      5'b11000: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | x_rs2 | x_rs1 | x_f3 |
            (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | opc;
        e = (si < -4096) || (si > 4095) || (imm % 2 != 0) || f3 == 2 || f3 == 3;
      end
      5'b00101, 5'b01101: begin
        w = (imm & 32'hFFFF_F000) | x_rd | opc;
        e = (imm & 32'hFFF) != 0;
      end
      5'b11011: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | x_rd | opc;
        e = (si < -(1 << 20)) || (si > (1 << 20) - 1) || (imm % 2 != 0);
      end
      default: e = 1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic set_req(input logic [4:0] op, input logic [2:0] f3, input logic f76,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_op = op; in_funct3 = f3; in_funct7_6 = f76;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic gen_random();
    logic [31:0] imm;
    logic [4:0]  op;
    op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      default: imm = $urandom;
    endcase
    if ($urandom_range(0, 1) == 1) imm = imm & 32'hFFFF_FFFE;
    if ((op == 5'b00101 || op == 5'b01101) && $urandom_range(0, 1) == 1) imm = imm & 32'hFFFF_F000;
    if (op == 5'b00100 && $urandom_range(0, 1) == 1) imm = imm & 32'h1F;
    set_req(op, 3'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom),
            5'($urandom), imm);
  endtask

  task automatic gen_legal();
    logic [31:0] w;
    logic        e;
    for (int t = 0; t < 2000; t++) begin
      gen_random();
      ref_encode(in_op, in_funct3, in_funct7_6, in_rd, in_rs1, in_rs2, in_imm, w, e);
      if (!e) break;
    end
    if (e) set_req(5'b00100, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5);
  endtask

  // One clock: check DUT against the model, then advance both.
  task automatic step();
    logic [31:0] w;
    logic        e;
    bit          acc, pp;
    check("in_ready", in_ready, q.size() < DEPTH);
    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("head_instr", out_instr, q[0].w);
      check("head_err", out_err, q[0].e);
    end
    check("enc_count", enc_count, enc_m);
    check("err_count", err_count, err_m);
    acc = in_valid && (q.size() < DEPTH);
    pp  = out_ready && (q.size() != 0);
    ref_encode(in_op, in_funct3, in_funct7_6, in_rd, in_rs1, in_rs2, in_imm, w, e);
    @(posedge clk); #1;
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back('{w: w, e: e});
      if (e) err_m = sat(err_m);
      else   enc_m = sat(enc_m);
      accepted++;
    end
    last_acc = acc;
  endtask

  task automatic directed(input string tag, input logic [4:0] op, input logic [2:0] f3,
                          input logic f76, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_w, input logic exp_e);
    set_req(op, f3, f76, rd, rs1, rs2, imm);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_word"}, out_instr, exp_w);
    check({tag, "_err"}, out_err, exp_e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete(); enc_m = 0; err_m = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(5'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_enc_count", enc_count, 0);
    check("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Directed legal encodings
    directed("add",  5'b01100, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 1'b0);
    directed("srai", 5'b00100, 3'd5, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3,          32'h4030D093, 1'b0);
    directed("addi", 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  32'hFFF00093, 1'b0);
    directed("sw",   5'b01000, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0);
    directed("beq",  5'b11000, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463, 1'b0);
    directed("jal",  5'b11011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       32'h001000EF, 1'b0);
    directed("lui",  5'b01101, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h123452B7, 1'b0);

    // Directed illegal requests
    directed("ill_addi", 5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h00000013, 1'b1);
    directed("ill_beq",  5'b11000, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7,    32'h00000013, 1'b1);
    directed("ill_op",   5'b11111, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0,    32'h00000013, 1'b1);
    check("err_count_3", err_count, 3);
    check("enc_count_7", enc_count, 7);

    // Fill with consumer stalled, then drain
    out_ready = 1'b0; in_valid = 1'b1;
    gen_legal();
    for (int i = 0; i < 6; i++) begin
      step();
      if (last_acc) gen_legal();
    end
    check("full_in_ready", in_ready, 1'b0);
    check("full_queue", q.size(), DEPTH);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_acc) in_valid = 1'b0;
    end
    check("drain_empty", out_valid, 1'b0);

    // Random mixed traffic with random back-pressure
    gen_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (last_acc || !in_valid) gen_random();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) step();

    // Sustained one-per-cycle throughput
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    acc0 = accepted;
    for (int i = 0; i < 100; i++) begin
      gen_legal();
      step();
    end
    in_valid = 1'b0;
    step();
    check("throughput", accepted - acc0, 100);
    check("enc_count_100", enc_count, 100);

    // Reset asserted with three words queued
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gen_legal();
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_enc", enc_count, 0);
    check("mid_rst_err", err_count, 0);
    check("mid_rst_instr", out_instr, 32'h0);
    #2;
    rst_n = 1'b1;
    q.delete(); enc_m = 0; err_m = 0;
    @(posedge clk); #1;
    directed("post_rst_add", 5'b01100, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3, 1'b0);

    // Counter saturation
    set_req(5'b00100, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("enc_sat", enc_count, 16'hFFFF);
    check("err_after_sat", err_count, 0);
    check("sat_drained", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
